// File: rtl/weight_loader_if.sv
// Host load port and core read port of the weight loader, bundled as one interface.
// master = host/core side, slave = weight_loader.
interface weight_loader_if #(
  parameter int AW = 4
);
  logic          write_mode;
  logic [7:0]    wr_data;
  logic          wr_strobe;
  logic [AW-1:0] addr_int;
  logic [7:0]    packet;
  logic          load_done;
  logic          checksum_ok;
  logic [4:0]    load_count;

  modport master (
    output write_mode, wr_data, wr_strobe, addr_int,
    input  packet, load_done, checksum_ok, load_count
  );

  modport slave (
    input  write_mode, wr_data, wr_strobe, addr_int,
    output packet, load_done, checksum_ok, load_count
  );
endinterface

// File: rtl/weight_loader.sv
// Weight memory loaded from a checksummed serial host stream; serves the core's
// registered SET/GET fetch only once a load has been validated.
module weight_loader #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  weight_loader_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [4:0] CNT_FULL = 5'(DEPTH);

  logic [1:0]       state;
  logic [2:0]       stb_pipe;
  logic [1:0][7:0]  dat_pipe;
  logic [7:0]       mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [7:0]       sum;
  logic [7:0]       sum_nxt;
  logic             stb_rise;
  logic             accept;
  logic             mem_we;
  logic             rd_en;

  // Two sync flops plus one delay flop; data rides the same two-flop depth as the strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stb_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      stb_pipe <= {stb_pipe[1:0], bus.wr_strobe};
      dat_pipe <= {dat_pipe[0], bus.wr_data};
    end
  end

  assign stb_rise = stb_pipe[1] & ~stb_pipe[2];
  assign accept   = (state == S_LOAD) && bus.write_mode && stb_rise;
  assign mem_we   = accept && (bus.load_count < CNT_FULL);
  assign sum_nxt  = sum + dat_pipe[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      wr_ptr          <= '0;
      sum             <= '0;
      bus.load_count  <= '0;
      bus.load_done   <= 1'b0;
      bus.checksum_ok <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.write_mode) begin
            state           <= S_LOAD;
            wr_ptr          <= '0;
            sum             <= '0;
            bus.load_count  <= '0;
            bus.load_done   <= 1'b0;
            bus.checksum_ok <= 1'b0;
          end
        end
        S_LOAD: begin
          // A falling write_mode wins over a strobe edge in the same cycle.
          if (!bus.write_mode) begin
            state           <= S_IDLE;
            bus.load_done   <= 1'b0;
            bus.checksum_ok <= 1'b0;
          end else if (mem_we) begin
            wr_ptr         <= wr_ptr + 1'b1;
            sum            <= sum_nxt;
            bus.load_count <= bus.load_count + 1'b1;
          end else if (accept) begin
            bus.checksum_ok <= (sum_nxt == 8'h00);
            bus.load_done   <= 1'b1;
            bus.load_count  <= CNT_FULL + 1'b1;
            state           <= S_DONE;
          end
        end
        S_DONE: begin
          if (!bus.write_mode) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (mem_we) begin
      mem[wr_ptr] <= dat_pipe[1];
    end
  end

  // Blank the read port from the edge that starts a load, so a reload never serves stale weights.
  assign rd_en = bus.checksum_ok && (state != S_LOAD) &&
                 !((state == S_IDLE) && bus.write_mode) &&
                 (32'(bus.addr_int) < 32'(DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     bus.packet <= '0;
    else if (rd_en) bus.packet <= mem[bus.addr_int];
    else            bus.packet <= '0;
  end
endmodule
